// File: rtl/rng_pkg.sv
// ---------------------------------------------------------------------------
// rng_pkg
// Definitions shared by the RNG output FIFO block:
//   - data widths of the RNG core word and of the bus-side read port
//   - number of bus words per stored entry
//   - capture FSM state encoding
//   - bus_slice(): selects one 32-bit word of a 128-bit entry
// ---------------------------------------------------------------------------
package rng_pkg;

  localparam int RNG_WORD_W      = 128;
  localparam int BUS_W           = 32;
  localparam int WORDS_PER_ENTRY = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } cap_state_e;

  // Word 0 is bits [31:0], word 3 is bits [127:96].
  function automatic logic [BUS_W-1:0] bus_slice(
    input logic [RNG_WORD_W-1:0] entry,
    input logic [1:0]            idx
  );
    logic [BUS_W-1:0] word;
    case (idx)
      2'd0:    word = entry[31:0];
      2'd1:    word = entry[63:32];
      2'd2:    word = entry[95:64];
      2'd3:    word = entry[127:96];
      default: word = entry[31:0];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/rng_fifo_mem.sv
// ---------------------------------------------------------------------------
// rng_fifo_mem
// DEPTH x 128-bit register array: one synchronous write port, one
// combinational read port. Contents are intentionally not reset; the
// pointer/count logic in the parent guarantees unwritten entries are
// never read.
// Ports:
//   clk    in   clock
//   we     in   write enable
//   waddr  in   write address (AW bits)
//   wdata  in   write data (128 bits)
//   raddr  in   read address (AW bits)
//   rdata  out  read data (128 bits), combinational from raddr
// ---------------------------------------------------------------------------
module rng_fifo_mem
  import rng_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [RNG_WORD_W-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [RNG_WORD_W-1:0] rdata
);

  logic [RNG_WORD_W-1:0] mem_r [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/rng_out_fifo.sv
// ---------------------------------------------------------------------------
// rng_out_fifo
// Captures 128-bit words from the RNG core through a vld/rddone handshake,
// buffers them in a DEPTH-entry FIFO and serves them to the bus side as
// 32-bit reads (bits [31:0] first).
// Ports:
//   clk, rstn            clock, async active-low reset
//   fifo_en              enables capture of new words
//   flush                one-cycle pulse: empty FIFO, clear sticky flag
//   rngcore_dataout      128-bit word from the RNG core
//   rngcore_dataout_vld  level, held by the core until acknowledged
//   rngcore_rddone       one-cycle acknowledge to the core
//   rd_en                one-cycle bus read strobe
//   rd_data, rd_vld      read data and its one-cycle valid
//   thresh               word threshold for irq_level
//   level_words          32-bit words available (registered)
//   fifo_empty/fifo_full occupancy status
//   irq_level            level reached threshold (thresh != 0)
//   underflow            sticky: read attempted while empty
// ---------------------------------------------------------------------------
module rng_out_fifo
  import rng_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  fifo_en,
  input  logic                  flush,
  input  logic [RNG_WORD_W-1:0] rngcore_dataout,
  input  logic                  rngcore_dataout_vld,
  output logic                  rngcore_rddone,
  input  logic                  rd_en,
  output logic [BUS_W-1:0]      rd_data,
  output logic                  rd_vld,
  input  logic [AW+2:0]         thresh,
  output logic [AW+2:0]         level_words,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  irq_level,
  output logic                  underflow
);

  localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
  localparam logic [1:0]    LAST_WORD = 2'(WORDS_PER_ENTRY - 1);
  localparam logic [AW+2:0] LVL_ZERO  = {(AW+3){1'b0}};

  cap_state_e            state_r;
  logic                  rddone_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [AW:0]           count_r;
  logic [1:0]            word_idx_r;
  logic [AW+2:0]         level_r;
  logic [BUS_W-1:0]      rd_data_r;
  logic                  rd_vld_r;
  logic                  underflow_r;

  logic [RNG_WORD_W-1:0] rd_entry_s;
  logic                  full_s;
  logic                  empty_s;
  logic                  push_s;
  logic                  rd_ok_s;
  logic                  pop_s;
  logic [AW:0]           count_nxt_s;
  logic [1:0]            word_idx_nxt_s;
  logic [AW+2:0]         level_nxt_s;
  logic [AW+2:0]         words_s;

  // Words are only ever partially consumed from a non-empty head entry,
  // so an empty FIFO is exactly count == 0.
  assign full_s  = (count_r == CNT_FULL);
  assign empty_s = (count_r == CNT_ZERO);
  assign words_s = {count_r, 2'b00} - {{(AW+1){1'b0}}, word_idx_r};

  // Captures only start from IDLE, so a vld still held for an already
  // acknowledged word (ACK/HOLD) can never be taken twice.
  assign push_s  = (state_r == IDLE) && fifo_en && rngcore_dataout_vld && !full_s && !flush;
  assign rd_ok_s = rd_en && !empty_s && !flush;
  assign pop_s   = rd_ok_s && (word_idx_r == LAST_WORD);

  // Next occupancy, word index and level.
  always_comb begin
    count_nxt_s    = count_r;
    word_idx_nxt_s = word_idx_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    // Two-bit index wraps to 0 on the pop of the fourth word.
    if (rd_ok_s) begin
      word_idx_nxt_s = word_idx_r + 2'd1;
    end else begin
      word_idx_nxt_s = word_idx_r;
    end
    level_nxt_s = {count_nxt_s, 2'b00} - {{(AW+1){1'b0}}, word_idx_nxt_s};
  end

  // Capture handshake FSM; flush deliberately leaves it untouched.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r  <= IDLE;
      rddone_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (push_s) begin
            state_r  <= ACK;
            rddone_r <= 1'b1;
          end else begin
            state_r  <= IDLE;
            rddone_r <= 1'b0;
          end
        end
        ACK: begin
          state_r  <= HOLD;
          rddone_r <= 1'b0;
        end
        HOLD: begin
          rddone_r <= 1'b0;
          if (!rngcore_dataout_vld) begin
            state_r <= IDLE;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r  <= IDLE;
          rddone_r <= 1'b0;
        end
      endcase
    end
  end

  // Pointers, occupancy, read port and sticky flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      word_idx_r  <= 2'd0;
      level_r     <= LVL_ZERO;
      rd_data_r   <= {BUS_W{1'b0}};
      rd_vld_r    <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      // rd_data keeps its last value; everything else returns to empty.
      wr_ptr_r    <= PTR_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      count_r     <= CNT_ZERO;
      word_idx_r  <= 2'd0;
      level_r     <= LVL_ZERO;
      rd_vld_r    <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_nxt_s;
      word_idx_r <= word_idx_nxt_s;
      level_r    <= level_nxt_s;
      rd_vld_r   <= rd_ok_s;
      if (rd_ok_s) begin
        rd_data_r <= bus_slice(rd_entry_s, word_idx_r);
      end
      if (rd_en && empty_s) begin
        underflow_r <= 1'b1;
      end
    end
  end

  rng_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (rngcore_dataout),
    .raddr (rd_ptr_r),
    .rdata (rd_entry_s)
  );

  assign rngcore_rddone = rddone_r;
  assign rd_data        = rd_data_r;
  assign rd_vld         = rd_vld_r;
  assign level_words    = level_r;
  assign underflow      = underflow_r;
  assign fifo_empty     = empty_s;
  assign fifo_full      = full_s;
  assign irq_level      = (thresh != LVL_ZERO) && (words_s >= thresh);

endmodule

// File: doc/rng_out_fifo.md
Name: rng_out_fifo

Overview:
- Downstream consumer of the RNG core's 128-bit output stage.
- Captures each rngcore_dataout word when rngcore_dataout_vld is high and acknowledges it with a one-cycle rngcore_rddone pulse.
- Stores words in a DEPTH-entry FIFO.
- Serves them to the bus-side register interface as 32-bit reads, with level/threshold status and sticky error flags.

Parameters:
- DEPTH, 4, number of 128-bit entries; power of two, 2..16.
- AW, 2, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous assert, active-low.
- fifo_en  in  1  enables capture; when 0, no new words are accepted (reads still served).
- flush  in  1  single-cycle pulse; empties the FIFO and clears the sticky flags.
- rngcore_dataout  in  128  data from the RNG core.
- rngcore_dataout_vld  in  1  level; held by the core until acknowledged.
- rngcore_rddone  out  1  one-cycle acknowledge to the core.
- rd_en  in  1  single-cycle read strobe from the bus side.
- rd_data  out  32  read data; valid with rd_vld.
- rd_vld  out  1  one-cycle pulse, one cycle after rd_en when data is returned.
- thresh  in  AW+3  word threshold for irq_level.
- level_words  out  AW+3  32-bit words available.
- fifo_empty  out  1  no words available.
- fifo_full  out  1  DEPTH entries occupied.
- irq_level  out  1  level_words >= thresh, and thresh != 0.
- underflow  out  1  sticky: rd_en seen while empty.

Behaviour:
- Reset values: all outputs 0, except fifo_empty=1. Pointers, count, word_idx, FSM and sticky flags are cleared. Storage is not reset.
- Capture FSM states:
  - IDLE:
    - fifo_en && vld && !full && !flush -> write entry at wr_ptr, wr_ptr+1, go to ACK.
    - Otherwise stay in IDLE.
  - ACK:
    - rngcore_rddone=1 for exactly this cycle.
    - Go to HOLD.
  - HOLD:
    - Wait for vld==0, then go to IDLE.
    - A vld still high from the already-acknowledged word is never captured twice.
  - A new word is accepted at the earliest 3 cycles after the previous capture.
- Full: the core is not acknowledged, so it holds its data. No overflow is possible by construction.
- Read path:
  - rd_en with words available -> rd_data = entry[rd_ptr][32*word_idx +: 32] on the next cycle, rd_vld=1.
  - Word order is bits [31:0] first.
  - word_idx increments modulo 4. On the 4th word the entry is popped: rd_ptr+1, count-1.
  - rd_en while empty -> rd_vld stays 0, rd_data unchanged, underflow set (sticky until flush or reset).
  - rd_data holds its last value between reads.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- level_words = count*4 - word_idx. It is registered and updated in the cycle following a push or pop.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Flush:
  - Clears the pointers, count, word_idx and underflow in one cycle.
  - Any push or read in the flush cycle is suppressed (no rd_vld).
  - The FSM state is not altered by flush: a pending ACK/HOLD completes normally, and the word captured in that ACK is already discarded.
- fifo_en dropping mid-ACK/HOLD: the handshake completes; only new captures are blocked.
- Status timing: fifo_empty, fifo_full and irq_level are derived combinationally from the registered count, word_idx and thresh.

Decomposition:
- Shared package rng_pkg:
  - RNG_WORD_W=128 and BUS_W=32.
  - WORDS_PER_ENTRY=4.
  - Capture FSM state encoding: IDLE=2'd0, ACK=2'd1, HOLD=2'd2.
- One sub-module, rng_fifo_mem: DEPTH x 128 register array with one write port and one read port.
- Pointers, FSM, word slicing and flags stay in the top module.

Test Plan:
- Reset then fifo_en=1; core presents 128'h0123..CDEF with vld held high -> rddone high in cycle 2 only. The word is not re-captured while vld stays high. level_words=4.
- Four rd_en pulses after one capture of 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> rd_data returns AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD in that order. fifo_empty=1 afterwards.
- Fill with DEPTH=4 words (level_words=16, fifo_full=1); core raises vld again -> no rddone. After 4 reads free one entry, rddone pulses and level_words=16 again.
- rd_en while empty -> no rd_vld, underflow=1 and stays 1. A flush pulse clears it to 0.
- thresh=6 with 2 entries stored (8 words) -> irq_level=1. After 3 reads (5 words) -> irq_level=0. With thresh=0, irq_level stays 0.
- Read the 4th word of an entry in the same cycle as a new capture -> count unchanged, both pointers advance. Also check pointer wrap after 9 consecutive entries flowing through: data order preserved.
